// File: rtl/div_sched.sv
// div_sched: round-robin front end that shares one iterative divider core among NREQ requesters.
// Latency: div_start 1 cycle after accept, rsp_valid 2+k cycles after accept (k = core latency); divide-by-zero answers 1 cycle after accept.
// Backpressure: one operation in flight; req_ready stays low from accept until the response is taken with rsp_valid && rsp_ready.
// Build option: define DIV_SCHED_TIMEOUT_EN to add a WAIT-state watchdog (parameter TIMEOUT).
module div_sched #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2,
    parameter int IDW   = 3
`ifdef DIV_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 64
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_dividend,
    input  logic [NREQ*WIDTH-1:0] req_divisor,
    output logic                  div_start,
    output logic [WIDTH-1:0]      div_dividend,
    output logic [WIDTH-1:0]      div_divisor,
    input  logic                  div_done,
    input  logic [WIDTH-1:0]      div_quotient,
    input  logic [WIDTH-1:0]      div_remainder,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_quotient,
    output logic [WIDTH-1:0]      rsp_remainder,
    output logic                  rsp_err,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_q, rr_d;
    logic             div_start_q, div_start_d;
    logic [WIDTH-1:0] div_dividend_q, div_dividend_d;
    logic [WIDTH-1:0] div_divisor_q, div_divisor_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_quotient_q, rsp_quotient_d;
    logic [WIDTH-1:0] rsp_remainder_q, rsp_remainder_d;
    logic             rsp_err_q, rsp_err_d;
    logic             busy_q, busy_d;

`ifdef DIV_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic [NREQ-1:0]  rot;
    logic             gnt_vld;
    int               gnt_pos;
    logic [IDW-1:0]   gnt_idx;
    logic [WIDTH-1:0] sel_dvd;
    logic [WIDTH-1:0] sel_dvs;

    // Round-robin pick: rotate valids so the pointer sits at bit 0, take the lowest set bit, map back.
    always_comb begin
        rot     = NREQ'({req_valid, req_valid} >> rr_q);
        gnt_vld = 1'b0;
        gnt_pos = 0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_vld && rot[k]) begin
                gnt_vld = 1'b1;
                gnt_pos = int'(rr_q) + k;
            end
        end
        if (gnt_pos >= NREQ) begin
            gnt_pos = gnt_pos - NREQ;
        end
        gnt_idx = IDW'(gnt_pos);
        if (state_q != IDLE) begin
            gnt_vld = 1'b0;
        end
        req_ready = '0;
        sel_dvd   = '0;
        sel_dvs   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_vld && gnt_pos == i) begin
                req_ready[i] = 1'b1;
                sel_dvd      = req_dividend[i*WIDTH +: WIDTH];
                sel_dvs      = req_divisor[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state and registered-output values for the accept/issue/wait/respond sequence.
    always_comb begin
        state_d         = state_q;
        rr_d            = rr_q;
        div_start_d     = 1'b0;
        div_dividend_d  = div_dividend_q;
        div_divisor_d   = div_divisor_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_id_d        = rsp_id_q;
        rsp_quotient_d  = rsp_quotient_q;
        rsp_remainder_d = rsp_remainder_q;
        rsp_err_d       = rsp_err_q;
`ifdef DIV_SCHED_TIMEOUT_EN
        cnt_d           = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    rsp_id_d       = gnt_idx;
                    rr_d           = (gnt_pos == NREQ - 1) ? '0 : IDW'(gnt_pos + 1);
                    div_dividend_d = sel_dvd;
                    div_divisor_d  = sel_dvs;
                    if (sel_dvs == '0) begin
                        // Divide-by-zero never reaches the core.
                        state_d         = RESP;
                        rsp_valid_d     = 1'b1;
                        rsp_quotient_d  = '1;
                        rsp_remainder_d = sel_dvd;
                        rsp_err_d       = 1'b1;
                    end else begin
                        state_d     = ISSUE;
                        div_start_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef DIV_SCHED_TIMEOUT_EN
                // Counts cycles since div_start, so the watchdog fires TIMEOUT cycles after launch.
                cnt_d   = CNT_W'(1);
`endif
            end
            WAIT: begin
                if (div_done) begin
                    state_d         = RESP;
                    rsp_valid_d     = 1'b1;
                    rsp_quotient_d  = div_quotient;
                    rsp_remainder_d = div_remainder;
                    rsp_err_d       = 1'b0;
                end
`ifdef DIV_SCHED_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d         = RESP;
                    rsp_valid_d     = 1'b1;
                    rsp_quotient_d  = '0;
                    rsp_remainder_d = '0;
                    rsp_err_d       = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; synchronous reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            rr_q            <= '0;
            div_start_q     <= 1'b0;
            div_dividend_q  <= '0;
            div_divisor_q   <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_id_q        <= '0;
            rsp_quotient_q  <= '0;
            rsp_remainder_q <= '0;
            rsp_err_q       <= 1'b0;
            busy_q          <= 1'b0;
`ifdef DIV_SCHED_TIMEOUT_EN
            cnt_q           <= '0;
`endif
        end else begin
            state_q         <= state_d;
            rr_q            <= rr_d;
            div_start_q     <= div_start_d;
            div_dividend_q  <= div_dividend_d;
            div_divisor_q   <= div_divisor_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_id_q        <= rsp_id_d;
            rsp_quotient_q  <= rsp_quotient_d;
            rsp_remainder_q <= rsp_remainder_d;
            rsp_err_q       <= rsp_err_d;
            busy_q          <= busy_d;
`ifdef DIV_SCHED_TIMEOUT_EN
            cnt_q           <= cnt_d;
`endif
        end
    end

    assign div_start     = div_start_q;
    assign div_dividend  = div_dividend_q;
    assign div_divisor   = div_divisor_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_quotient  = rsp_quotient_q;
    assign rsp_remainder = rsp_remainder_q;
    assign rsp_err       = rsp_err_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: drives div_sched with directed and random requester traffic plus a divider core model.
// Expected behaviour comes from a transaction-level model (accept time, due time, arithmetic results).
// Inputs change on the falling edge; outputs are sampled 1 time unit after it.
module tb_div_sched;
    localparam int WIDTH = 8;
    localparam int NREQ  = 2;
    localparam int IDW   = 3;
    localparam int K_DEF = 8;
    localparam int TMO   = 64;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_dividend;
    logic [NREQ*WIDTH-1:0] req_divisor;
    logic                  div_start;
    logic [WIDTH-1:0]      div_dividend;
    logic [WIDTH-1:0]      div_divisor;
    logic                  div_done;
    logic [WIDTH-1:0]      div_quotient;
    logic [WIDTH-1:0]      div_remainder;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_quotient;
    logic [WIDTH-1:0]      rsp_remainder;
    logic                  rsp_err;
    logic                  busy;

    div_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
        .rsp_err(rsp_err), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // requester-side stimulus
    logic [NREQ-1:0]  rv;
    logic [WIDTH-1:0] ra [NREQ];
    logic [WIDTH-1:0] rb [NREQ];
    bit rsp_rdy_b, in_reset, sticky, spur_en, spur_force, core_live, rand_k;

    // divider core model
    int core_cnt, cur_k;
    logic [WIDTH-1:0] core_a, core_b;

    // transaction-level reference model
    bit m_busy;
    int m_ptr, m_start, m_due, m_id;
    logic [WIDTH-1:0] m_dvd, m_dvs, m_q, m_r;
    bit m_err;
    int acc_cyc, hs_cyc;
    int grants[$];

    // observations of the DUT for directed latency/value checks
    int rise_cyc, n_start, s0;
    logic [WIDTH-1:0] obs_q, obs_r;
    logic [IDW-1:0] obs_id;
    logic obs_err, rv_prev;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at cycle %0d", tag, got, want, cyc);
        end
    endtask

    task automatic model_step();
        int g;
        logic [NREQ-1:0] exp_rdy;
        bit exp_start, exp_rv;
        g = -1;
        if (!m_busy) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (g < 0 && rv[i]) g = i;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy = NREQ'(1) << g;
        chk("req_ready", req_ready, exp_rdy);
        chk("busy", busy, m_busy);
        exp_start = m_busy && (cyc == m_start);
        chk("div_start", div_start, exp_start);
        if (exp_start) begin
            chk("div_dividend", div_dividend, m_dvd);
            chk("div_divisor", div_divisor, m_dvs);
        end
        exp_rv = m_busy && (cyc >= m_due);
        chk("rsp_valid", rsp_valid, exp_rv);
        if (exp_rv) begin
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_quotient", rsp_quotient, m_q);
            chk("rsp_remainder", rsp_remainder, m_r);
            chk("rsp_err", rsp_err, m_err);
        end
        if (exp_rv && rsp_ready) begin
            m_busy = 1'b0;
            hs_cyc = cyc;
        end else if (g >= 0) begin
            m_busy  = 1'b1;
            m_id    = g;
            m_dvd   = ra[g];
            m_dvs   = rb[g];
            m_ptr   = (g + 1) % NREQ;
            acc_cyc = cyc;
            grants.push_back(g);
            if (m_dvs == 0) begin
                m_start = -1;
                m_due   = cyc + 1;
                m_q     = '1;
                m_r     = m_dvd;
                m_err   = 1'b1;
            end else begin
                m_start = cyc + 1;
                cur_k   = rand_k ? int'($urandom_range(1, 12)) : K_DEF;
                if (core_live) begin
                    m_due = cyc + 2 + cur_k;
                    m_q   = m_dvd / m_dvs;
                    m_r   = m_dvd % m_dvs;
                    m_err = 1'b0;
                end else begin
                    m_due = cyc + 1 + TMO;
                    m_q   = '0;
                    m_r   = '0;
                    m_err = 1'b1;
                end
            end
            if (!sticky) rv[g] = 1'b0;
        end
    endtask

    task automatic run_cycle();
        @(negedge clk);
        // divider core: done k cycles after it sees div_start, plus optional stray done pulses
        div_done = 1'b0;
        if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0 && core_live) begin
                div_done      = 1'b1;
                div_quotient  = (core_b == 0) ? '1 : core_a / core_b;
                div_remainder = (core_b == 0) ? core_a : core_a % core_b;
            end
        end
        if (core_cnt == 0 && !div_done && (!m_busy || cyc >= m_due) &&
            (spur_force || (spur_en && $urandom_range(0, 15) == 0))) begin
            div_done      = 1'b1;
            div_quotient  = WIDTH'($urandom);
            div_remainder = WIDTH'($urandom);
        end
        if (div_start === 1'b1) begin
            core_cnt = cur_k;
            core_a   = div_dividend;
            core_b   = div_divisor;
        end
        reset     = in_reset;
        req_valid = rv;
        for (int i = 0; i < NREQ; i++) begin
            req_dividend[i*WIDTH +: WIDTH] = ra[i];
            req_divisor[i*WIDTH +: WIDTH]  = rb[i];
        end
        rsp_ready = rsp_rdy_b;
        #1;
        if (!in_reset) begin
            if (rsp_valid && !rv_prev) begin
                rise_cyc = cyc;
                obs_q    = rsp_quotient;
                obs_r    = rsp_remainder;
                obs_id   = rsp_id;
                obs_err  = rsp_err;
            end
            if (div_start) n_start++;
            model_step();
        end
        rv_prev = rsp_valid;
        cyc++;
    endtask

    task automatic do_reset();
        in_reset = 1'b1;
        rv = '0;
        repeat (3) run_cycle();
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_div_start", div_start, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_q", rsp_quotient, 0);
        chk("rst_rsp_r", rsp_remainder, 0);
        chk("rst_div_dvd", div_dividend, 0);
        chk("rst_div_dvs", div_divisor, 0);
        in_reset = 1'b0;
        m_busy   = 1'b0;
        m_ptr    = 0;
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < NREQ; i++) begin
            if (!rv[i]) begin
                if ($urandom_range(0, 2) == 0) begin
                    rv[i] = 1'b1;
                    ra[i] = WIDTH'($urandom);
                    rb[i] = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
                end
            end else if ($urandom_range(0, 31) == 0) begin
                rv[i] = 1'b0;
            end
        end
        rsp_rdy_b = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_dividend = '0; req_divisor = '0; rsp_ready = 1'b0;
        div_done = 1'b0; div_quotient = '0; div_remainder = '0;
        rv = '0;
        for (int i = 0; i < NREQ; i++) begin ra[i] = '0; rb[i] = '0; end
        rsp_rdy_b = 1'b1; in_reset = 1'b0; sticky = 1'b0; spur_en = 1'b0; spur_force = 1'b0;
        core_live = 1'b1; rand_k = 1'b0; cur_k = K_DEF; core_cnt = 0; core_a = '0; core_b = '0;
        m_busy = 1'b0; m_ptr = 0; m_start = -1; m_due = 0; m_id = 0; m_dvd = '0; m_dvs = '0;
        m_q = '0; m_r = '0; m_err = 1'b0; acc_cyc = 0; hs_cyc = 0;
        rise_cyc = 0; n_start = 0; s0 = 0; obs_q = '0; obs_r = '0; obs_id = '0; obs_err = 1'b0;
        rv_prev = 1'b0;

        do_reset();

        // single request 200/7
        s0 = n_start;
        rv[0] = 1'b1; ra[0] = 8'd200; rb[0] = 8'd7;
        repeat (14) run_cycle();
        chk("single_lat", rise_cyc - acc_cyc, 10);
        chk("single_q", obs_q, 28);
        chk("single_r", obs_r, 4);
        chk("single_id", obs_id, 0);
        chk("single_err", obs_err, 0);
        chk("single_starts", n_start - s0, 1);

        // divide-by-zero on requester 1
        s0 = n_start;
        rv[1] = 1'b1; ra[1] = 8'd55; rb[1] = 8'd0;
        repeat (4) run_cycle();
        chk("dz_lat", rise_cyc - acc_cyc, 1);
        chk("dz_q", obs_q, 8'hFF);
        chk("dz_r", obs_r, 55);
        chk("dz_err", obs_err, 1);
        chk("dz_id", obs_id, 1);
        chk("dz_starts", n_start - s0, 0);

        // contention from reset: both requesters always valid
        do_reset();
        grants.delete();
        sticky = 1'b1;
        rv = '1; ra[0] = 8'd100; rb[0] = 8'd9; ra[1] = 8'd9; rb[1] = 8'd100;
        repeat (46) run_cycle();
        sticky = 1'b0; rv = '0;
        repeat (14) run_cycle();
        chk("cont_ngrants", grants.size() >= 4, 1);
        if (grants.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("cont_order", grants[i], i % 2);
        end

        // response backpressure with a second requester waiting
        s0 = n_start;
        rsp_rdy_b = 1'b0;
        rv[0] = 1'b1; ra[0] = 8'd200; rb[0] = 8'd7;
        run_cycle();
        rv[1] = 1'b1; ra[1] = 8'd77; rb[1] = 8'd5;
        repeat (15) run_cycle();
        chk("bp_starts", n_start - s0, 1);
        rsp_rdy_b = 1'b1;
        repeat (2) run_cycle();
        chk("bp_next_acc", acc_cyc - hs_cyc, 1);
        repeat (12) run_cycle();

        // reset while waiting on the core, pointer left at 1 beforehand
        rv[0] = 1'b1; ra[0] = 8'd123; rb[0] = 8'd10;
        repeat (5) run_cycle();
        chk("rw_busy_pre", busy, 1);
        do_reset();
        repeat (12) run_cycle();
        grants.delete();
        rv = '1; ra[0] = 8'd40; rb[0] = 8'd6; ra[1] = 8'd41; rb[1] = 8'd7;
        run_cycle();
        chk("rw_ptr_grant", grants.size() == 1 && grants[0] == 0, 1);
        repeat (30) run_cycle();
        rv = '0;
        repeat (12) run_cycle();

`ifdef DIV_SCHED_TIMEOUT_EN
        // core never answers: watchdog response, then stray done pulses ignored
        core_live = 1'b0;
        rsp_rdy_b = 1'b0;
        rv[0] = 1'b1; ra[0] = 8'd50; rb[0] = 8'd3;
        repeat (68) run_cycle();
        spur_force = 1'b1;
        repeat (2) run_cycle();
        spur_force = 1'b0;
        chk("tmo_lat", rise_cyc - acc_cyc, TMO + 1);
        chk("tmo_q", obs_q, 0);
        chk("tmo_r", obs_r, 0);
        chk("tmo_err", obs_err, 1);
        rsp_rdy_b = 1'b1;
        run_cycle();
        spur_force = 1'b1;
        repeat (3) run_cycle();
        spur_force = 1'b0;
        core_live = 1'b1;
        repeat (10) run_cycle();
`endif

        // random traffic with variable core latency and stray done pulses
        spur_en = 1'b1;
        rand_k  = 1'b1;
        repeat (3000) begin
            rand_inputs();
            run_cycle();
        end
        spur_en = 1'b0;
        rv = '0;
        rsp_rdy_b = 1'b1;
        repeat (20) run_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
